// File: rtl/ping_sequencer.sv
// ping_sequencer: sequences one sonar measurement (ping) -- transducer burst,
// ring-down blanking, listen window with timeout, cooldown -- and feeds the
// time-of-flight range calculator with time_since_emission and echo_detected.
// Optional build macro: PING_AUTO_REARM_EN. When defined, the end of cooldown
// launches the next burst directly (continuous ranging). When undefined,
// cooldown returns to IDLE and every ping needs its own start_in.
module ping_sequencer #(
    parameter int unsigned EMIT_CYCLES       = 20000,
    parameter int unsigned BLANK_CYCLES      = 100000,
    parameter int unsigned MAX_LISTEN_CYCLES = 3000000,
    parameter int unsigned COOLDOWN_CYCLES   = 1000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        abort_in,
    input  logic        echo_in,
    output logic        emit_out,
    output logic [31:0] time_since_emission,
    output logic        echo_detected,
    output logic        done_out,
    output logic        timeout_out,
    output logic        busy_out,
    output logic [15:0] ping_count_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_BLANK,
        S_LISTEN,
        S_COOLDOWN
    } state_t;

    // Phase boundaries are expressed in time_since_emission units, which is
    // 0 in the first EMIT cycle, so the emission counter doubles as the
    // burst and blanking timer.
    localparam logic [31:0] EMIT_LAST  = 32'(EMIT_CYCLES - 1);
    localparam logic [31:0] BLANK_LAST = 32'(EMIT_CYCLES + BLANK_CYCLES - 1);
    localparam logic [31:0] MAX_LISTEN = 32'(MAX_LISTEN_CYCLES);
    localparam logic [31:0] COOL_LAST  = 32'(COOLDOWN_CYCLES - 1);

`ifdef PING_AUTO_REARM_EN
    localparam state_t COOL_EXIT = S_EMIT;
`else
    localparam state_t COOL_EXIT = S_IDLE;
`endif

    state_t      state_q, state_d;
    logic        echo_meta_q, echo_s_q;
    logic [31:0] tse_q, tse_d;
    logic [31:0] cool_q, cool_d;
    logic [15:0] count_q, count_d;
    logic        det_q, det_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        emit_q, busy_q;
    logic        window_now, window_next;

    // The emission counter only runs while the ping is in flight.
    assign window_now  = (state_q == S_EMIT) || (state_q == S_BLANK) || (state_q == S_LISTEN);
    assign window_next = (state_d == S_EMIT) || (state_d == S_BLANK) || (state_d == S_LISTEN);

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            echo_meta_q <= echo_in;
            echo_s_q    <= echo_meta_q;
        end
    end

    // Next-state, counter and pulse decisions; abort overrides capture/timeout.
    always_comb begin
        state_d   = state_q;
        tse_d     = tse_q;
        cool_d    = cool_q;
        count_d   = count_q;
        det_d     = det_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (tse_q == EMIT_LAST) begin
                    state_d = (BLANK_CYCLES == 0) ? S_LISTEN : S_BLANK;
                end
            end
            S_BLANK: begin
                if (tse_q == BLANK_LAST) begin
                    state_d = S_LISTEN;
                end
            end
            S_LISTEN: begin
                // Echo is checked first so it wins a tie with the timeout.
                if (echo_s_q) begin
                    det_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_COOLDOWN;
                end else if (tse_q == MAX_LISTEN) begin
                    timeout_d = 1'b1;
                    state_d   = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cool_q == COOL_LAST) begin
                    state_d = COOL_EXIT;
                end else begin
                    cool_d = cool_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops the ping silently and leaves echo_detected untouched.
        if (abort_in && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            det_d     = det_q;
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end

        if ((state_d == S_COOLDOWN) && (state_q != S_COOLDOWN)) begin
            cool_d = '0;
        end

        // Burst entry starts a fresh ping; otherwise the counter advances only
        // while staying in flight, so it freezes on capture, timeout or abort.
        if ((state_d == S_EMIT) && (state_q != S_EMIT)) begin
            count_d = count_q + 16'd1;
            det_d   = 1'b0;
            tse_d   = '0;
        end else if (window_now && window_next && (tse_q != 32'hFFFF_FFFF)) begin
            tse_d = tse_q + 32'd1;
        end
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            tse_q     <= '0;
            cool_q    <= '0;
            count_q   <= '0;
            det_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            emit_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tse_q     <= tse_d;
            cool_q    <= cool_d;
            count_q   <= count_d;
            det_q     <= det_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            emit_q    <= (state_d == S_EMIT);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign emit_out            = emit_q;
    assign time_since_emission = tse_q;
    assign echo_detected       = det_q;
    assign done_out            = done_q;
    assign timeout_out         = timeout_q;
    assign busy_out            = busy_q;
    assign ping_count_out      = count_q;

endmodule
